writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
- Write-side producer for the 32x32 MIPS register file. Collects completed results from the ALU path and the memory-load path and queues them in a small in-order FIFO.
- Drains the FIFO onto the register file write port (RegWrite / WriteRegister / WriteData) at one write per cycle.
- Exposes per-read-port hazard flags so the decode stage can stall on registers with pending writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 5, register index width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- AluValid  in  1  ALU result present this cycle
- AluReg  in  ADDR_W  ALU destination register
- AluData  in  DATA_W  ALU result
- MemValid  in  1  load result present this cycle
- MemReg  in  ADDR_W  load destination register
- MemData  in  DATA_W  load data
- Flush  in  1  synchronous discard of all queued, not-yet-issued entries
- Ready  out  1  buffer can take up to two pushes this cycle
- RegWrite  out  1  register file write enable, registered
- WriteRegister  out  ADDR_W  write index, registered
- WriteData  out  DATA_W  write data, registered
- ReadRegister1  in  ADDR_W  decode read port 1 index
- ReadRegister2  in  ADDR_W  decode read port 2 index
- Hazard1  out  1  pending write to ReadRegister1
- Hazard2  out  1  pending write to ReadRegister2
- Count  out  $clog2(DEPTH+1)  queued entries
- Overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (async, rst_n=0), immediate and independent of clk:
  - RegWrite=0, WriteRegister=0, WriteData=0, Count=0, Overflow=0.
  - FIFO pointers cleared; Ready=1.
  - Reset mid-drain abandons all entries.
- Ready = (DEPTH − Count) ≥ 2. Combinational from registered Count only.
- Push, sampled at the rising edge:
  - A source with Valid=1 and Reg≠0 pushes one entry.
  - Valid with Reg=0 is silently discarded: no slot used, no Overflow.
  - Both sources in the same cycle: the Mem entry is enqueued ahead of the Alu entry.
- Valid=1 (Reg≠0) while Ready=0: that push is dropped and Overflow is set to 1. Overflow clears only on reset.
- Pop:
  - At each edge, if Count (pre-edge value) > 0, the head entry is loaded into WriteRegister/WriteData, RegWrite=1 for exactly that following cycle, and head advances.
  - Otherwise RegWrite=0 and WriteRegister/WriteData hold their last values.
- Push and pop in the same cycle are both honoured. Count update = pushes − pop.
- Latency: an entry pushed at edge N onto an empty queue is presented at edge N+1 and committed by the register file at edge N+2. There is no push-to-output bypass.
- Ordering: strict FIFO. Two writes to the same register commit in enqueue order, so the last write wins.
- Pointers wrap modulo DEPTH.
- Flush=1 at an edge:
  - Clears the queue (Count=0) and drops any pushes in that cycle. Overflow is not set.
  - RegWrite=0 for the next cycle; a write already presented in the flush cycle completes normally.
- Hazardk (combinational) = ReadRegisterk≠0 AND (ReadRegisterk matches any valid FIFO entry OR (RegWrite=1 AND WriteRegister==ReadRegisterk)).
  - Incoming same-cycle pushes are not included.
  - ReadRegisterk=0 always gives Hazardk=0.

Test Plan:
- Reset mid-operation: queue 3 entries, pulse rst_n low between edges -> RegWrite, WriteRegister, WriteData, Count, Overflow all 0 immediately; Ready=1; no writes after release.
- Single push: AluValid, AluReg=8, AluData=0x12345678 at edge 1 -> RegWrite=1 only in the cycle after edge 2 with WriteRegister=8, WriteData=0x12345678. With ReadRegister1=8, Hazard1=1 from after edge 1 through the cycle after edge 2, and 0 after edge 3.
- Simultaneous push, same register: Mem(9, 0xAAAA0000) and Alu(9, 0x00005555) together -> writes in consecutive cycles, 0xAAAA0000 then 0x00005555; register 9 final value 0x00005555.
- Register zero: AluValid, AluReg=0, AluData=0xFFFFFFFF -> Count unchanged, no RegWrite. With ReadRegister2=0, Hazard2=0 throughout.
- Full/overflow (DEPTH=4): push both sources every cycle -> Ready=0 once Count≥3. Keep asserting AluValid with AluReg=5 -> Overflow=1 (sticky), that entry is never written, and earlier entries drain in order.
- Flush: 3 entries queued, Flush=1 for one edge -> Count=0 next cycle, no further RegWrite pulses beyond one already presented, Hazard1/Hazard2 deassert, Overflow unchanged.

Source files
------------

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order write queue in front of the 32x32 register file.
// Collects ALU and load results, drains one register file write per cycle
// and flags decode read ports that still have a write pending.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   AluValid/AluReg/AluData         ALU result push
//   MemValid/MemReg/MemData         load result push (queued ahead of ALU)
//   Flush                           discard every queued entry
//   Ready                           at least two free slots
//   RegWrite/WriteRegister/WriteData registered register file write port
//   ReadRegister1/2, Hazard1/2      decode read ports and pending-write flags
//   Count                           queued entries
//   Overflow                        sticky, a push was dropped
module writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  input  logic              Flush,
  output logic              Ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow
);

  logic [DEPTH-1:0][ADDR_W-1:0] regQ;
  logic [DEPTH-1:0][DATA_W-1:0] dataQ;
  logic [PTR_W-1:0] head, tail, aluIdx, idx;
  logic memPush, aluPush, memAcc, aluAcc, doPop, dropPush;
  logic [CNT_W-1:0] countNext;

  // Two free slots required so a dual push never needs a partial accept.
  assign Ready    = (Count <= CNT_W'(DEPTH-2));
  // Writes to register zero are architecturally void; never queue them.
  assign memPush  = MemValid && (MemReg != '0);
  assign aluPush  = AluValid && (AluReg != '0);
  assign memAcc   = memPush && Ready && !Flush;
  assign aluAcc   = aluPush && Ready && !Flush;
  assign dropPush = (memPush || aluPush) && !Ready && !Flush;
  assign doPop    = (Count != '0) && !Flush;
  assign aluIdx   = tail + PTR_W'(memAcc);
  assign countNext = Count + CNT_W'(memAcc) + CNT_W'(aluAcc) - CNT_W'(doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      Count         <= '0;
      Overflow      <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      regQ          <= '0;
      dataQ         <= '0;
    end else begin
      RegWrite <= doPop;
      if (doPop) begin
        WriteRegister <= regQ[head];
        WriteData     <= dataQ[head];
      end
      if (Flush) begin
        head  <= '0;
        tail  <= '0;
        Count <= '0;
      end else begin
        if (doPop) head <= head + PTR_W'(1);
        if (memAcc) begin
          regQ[tail]  <= MemReg;
          dataQ[tail] <= MemData;
        end
        if (aluAcc) begin
          regQ[aluIdx]  <= AluReg;
          dataQ[aluIdx] <= AluData;
        end
        tail  <= tail + PTR_W'(memAcc) + PTR_W'(aluAcc);
        Count <= countNext;
      end
      if (dropPush) Overflow <= 1'b1;
    end
  end

  // Scan only the occupied window [head, head+Count); stale slots are ignored.
  always_comb begin
    Hazard1 = 1'b0;
    Hazard2 = 1'b0;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < Count) begin
        if (regQ[idx] == ReadRegister1) Hazard1 = 1'b1;
        if (regQ[idx] == ReadRegister2) Hazard2 = 1'b1;
      end
    end
    // The write on the port this cycle is not yet in the register file.
    if (RegWrite && WriteRegister == ReadRegister1) Hazard1 = 1'b1;
    if (RegWrite && WriteRegister == ReadRegister2) Hazard2 = 1'b1;
    if (ReadRegister1 == '0) Hazard1 = 1'b0;
    if (ReadRegister2 == '0) Hazard2 = 1'b0;
  end

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic AluValid = 1'b0, MemValid = 1'b0, Flush = 1'b0;
  logic [AW-1:0] AluReg = '0, MemReg = '0, ReadRegister1 = '0, ReadRegister2 = '0;
  logic [DW-1:0] AluData = '0, MemData = '0;
  logic Ready, RegWrite, Hazard1, Hazard2, Overflow;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [2:0] Count;

  writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData),
    .Flush(Flush), .Ready(Ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Hazard1(Hazard1), .Hazard2(Hazard2), .Count(Count), .Overflow(Overflow));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  // Scoreboard: entries expected inside the FIFO, in commit order.
  ent_t fifoQ[$];
  logic expRW = 1'b0, expOvf = 1'b0;
  logic [AW-1:0] expWR = '0;
  logic [DW-1:0] expWD = '0;
  int nCmp = 0, nFail = 0;

  typedef struct {
    logic mv; logic [AW-1:0] mr; logic [DW-1:0] md;
    logic av; logic [AW-1:0] ar; logic [DW-1:0] ad;
    logic fl; logic [AW-1:0] r1; logic [AW-1:0] r2;
    int expCount; logic expRWv; logic [AW-1:0] expWRv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic modelHaz(input logic [AW-1:0] rr);
    if (rr == '0) return 1'b0;
    foreach (fifoQ[i]) if (fifoQ[i].r == rr) return 1'b1;
    return expRW && (expWR == rr);
  endfunction

  // Drive one cycle of stimulus, advance the model, check outputs after the edge.
  task automatic cycle(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic fl, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    int sz;
    bit rdy, pop, mP, aP;
    ent_t e;
    MemValid = mv; MemReg = mr; MemData = md;
    AluValid = av; AluReg = ar; AluData = ad;
    Flush = fl; ReadRegister1 = r1; ReadRegister2 = r2;
    sz  = fifoQ.size();
    rdy = (DEPTH - sz) >= 2;
    pop = (sz > 0) && !fl;
    mP  = mv && (mr != 0);
    aP  = av && (ar != 0);
    if (pop) begin
      e = fifoQ.pop_front();
      expRW = 1'b1; expWR = e.r; expWD = e.d;
    end else expRW = 1'b0;
    if (fl) fifoQ.delete();
    else if (rdy) begin
      if (mP) begin e.r = mr; e.d = md; fifoQ.push_back(e); end
      if (aP) begin e.r = ar; e.d = ad; fifoQ.push_back(e); end
    end else if (mP || aP) expOvf = 1'b1;
    @(posedge clk); #1;
    chk("RegWrite", 32'(RegWrite), 32'(expRW));
    chk("WriteRegister", 32'(WriteRegister), 32'(expWR));
    chk("WriteData", WriteData, expWD);
    chk("Count", 32'(Count), 32'(fifoQ.size()));
    chk("Ready", 32'(Ready), 32'((DEPTH - fifoQ.size()) >= 2));
    chk("Overflow", 32'(Overflow), 32'(expOvf));
    chk("Hazard1", 32'(Hazard1), 32'(modelHaz(ReadRegister1)));
    chk("Hazard2", 32'(Hazard2), 32'(modelHaz(ReadRegister2)));
  endtask

  task automatic idle(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic chkReset();
    chk("rst RegWrite", 32'(RegWrite), 0);
    chk("rst WriteRegister", 32'(WriteRegister), 0);
    chk("rst WriteData", WriteData, 0);
    chk("rst Count", 32'(Count), 0);
    chk("rst Overflow", 32'(Overflow), 0);
    chk("rst Ready", 32'(Ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //         mv  mr    md            av  ar    ad            fl  r1    r2    cnt rw  wr
    tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h12345678, 1'b0, 5'd8, 5'd0, 1, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 5'd0, 0, 1'b1, 5'd8};
    tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 5'd0, 0, 1'b0, 5'd8};
    tbl[3] = '{1'b1, 5'd9, 32'hAAAA0000, 1'b1, 5'd9, 32'h00005555, 1'b0, 5'd9, 5'd0, 2, 1'b0, 5'd8};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd0, 1, 1'b1, 5'd9};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd0, 0, 1'b1, 5'd9};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 0, 1'b0, 5'd9};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 0, 1'b0, 5'd9};

    #2;
    chkReset();
    #10 rst_n = 1'b1;

    // Table-driven: single push, dual push to one register, register zero.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].av, tbl[i].ar, tbl[i].ad,
            tbl[i].fl, tbl[i].r1, tbl[i].r2);
      chk($sformatf("tbl%0d Count", i), 32'(Count), 32'(tbl[i].expCount));
      chk($sformatf("tbl%0d RegWrite", i), 32'(RegWrite), 32'(tbl[i].expRWv));
      chk($sformatf("tbl%0d WriteRegister", i), 32'(WriteRegister), 32'(tbl[i].expWRv));
      if (i == 5) chk("last write wins", WriteData, 32'h00005555);
    end

    // Fill to Count=3, then an ALU push to r5 while not Ready is dropped.
    cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd1, 5'd2);
    cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 5'd3, 5'd4);
    chk("full Ready", 32'(Ready), 0);
    cycle(0, 5'd0, 32'h0, 1, 5'd5, 32'h55, 0, 5'd5, 5'd4);
    chk("ovf sticky set", 32'(Overflow), 1);
    idle(5, 5'd5, 5'd4);
    chk("ovf still set", 32'(Overflow), 1);

    // Flush with three entries queued; one write is already presented.
    cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 5'd12, 5'd13);
    cycle(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0, 0, 5'd12, 5'd13);
    chk("pre-flush Count", 32'(Count), 3);
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd12, 5'd13);
    chk("flush Count", 32'(Count), 0);
    chk("flush Hazard1", 32'(Hazard1), 0);
    chk("flush Hazard2", 32'(Hazard2), 0);
    idle(3, 5'd11, 5'd12);

    // Reset between edges with entries queued.
    cycle(1, 5'd20, 32'h200, 1, 5'd21, 32'h210, 0, 5'd20, 5'd21);
    cycle(1, 5'd22, 32'h220, 1, 5'd23, 32'h230, 0, 5'd22, 5'd23);
    #2 rst_n = 1'b0;
    #1 chkReset();
    fifoQ.delete();
    expRW = 1'b0; expWR = '0; expWD = '0; expOvf = 1'b0;
    #1 rst_n = 1'b1;
    idle(4, 5'd22, 5'd23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
